// File: rtl/sync_code_decoder.sv
// sync_code_decoder: regenerates frame/line/pixel timing from embedded FFF,000,000,code sync words.
// Optional bitslip lock monitor is enabled by defining SYNC_CODE_DECODER_LOCK_MON_EN.
module sync_code_decoder #(
    parameter int unsigned       DATA_W       = 12,
    parameter logic [DATA_W-1:0] SAV_ACT      = 12'h800,
    parameter logic [DATA_W-1:0] EAV_ACT      = 12'h9D0,
    parameter logic [DATA_W-1:0] SAV_BLK      = 12'hAB0,
    parameter logic [DATA_W-1:0] EAV_BLK      = 12'hB60,
    parameter int unsigned       CNT_W        = 16,
    parameter int unsigned       EXP_WIDTH    = 0,
    parameter int unsigned       LOCK_TIMEOUT = 4096
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_data_valid,
    input  logic [DATA_W-1:0] I_data,
`ifdef SYNC_CODE_DECODER_LOCK_MON_EN
    input  logic              I_bitslip_done,
    output logic              O_bitslip_error,
`endif
    output logic              O_frame_valid,
    output logic              O_line_valid,
    output logic              O_data_valid,
    output logic [DATA_W-1:0] O_data,
    output logic              O_frame_start,
    output logic              O_frame_end,
    output logic [CNT_W-1:0]  O_line_len,
    output logic [CNT_W-1:0]  O_frame_lines,
    output logic              O_code_err,
    output logic              O_len_err
);
    typedef enum logic [1:0] {StIdle, StVblank, StLine, StHblank} state_e;

    state_e            r_state, w_state_next;
    logic [DATA_W-1:0] r_hist [4];
    logic [3:0]        r_tag;
    logic [CNT_W-1:0]  r_pix_cnt, r_line_cnt, w_pix_cnt_next, w_line_cnt_next;
    logic [CNT_W-1:0]  r_line_len, r_frame_lines;
    logic [DATA_W-1:0] r_data;
    logic              r_data_valid, r_frame_start, r_frame_end, r_code_err, r_len_err;
    logic              w_pre, w_sav_act, w_eav_act, w_blank, w_known, w_pix_out;
    logic              w_code_err, w_frame_start, w_frame_end, w_line_done, w_cnt_restart;

    // The incoming word is the code; the three words before it must be the preamble.
    assign w_pre     = I_data_valid && (r_hist[2] == '1) && (r_hist[1] == '0)
                       && (r_hist[0] == '0);
    assign w_sav_act = (I_data == SAV_ACT);
    assign w_eav_act = (I_data == EAV_ACT);
    assign w_blank   = (I_data == SAV_BLK) || (I_data == EAV_BLK);
    assign w_known   = w_sav_act || w_eav_act || w_blank;
    // A tagged word leaving the 4-deep history is a pixel.
    assign w_pix_out = I_data_valid && r_tag[3];

    always_comb begin
        w_state_next  = r_state;
        w_code_err    = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_line_done   = 1'b0;
        w_cnt_restart = 1'b0;
        if (w_pre) begin
            if (!w_known) begin
                w_code_err = 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_blank) w_state_next = StVblank;
                    end
                    StVblank: begin
                        if (w_sav_act) begin
                            w_state_next  = StLine;
                            w_frame_start = 1'b1;
                            w_cnt_restart = 1'b1;
                        end
                    end
                    StLine: begin
                        if (w_eav_act) begin
                            w_state_next = StHblank;
                            w_line_done  = 1'b1;
                        end else if (w_sav_act) begin
                            w_code_err    = 1'b1;
                            w_cnt_restart = 1'b1;
                        end else begin
                            w_code_err   = 1'b1;
                            w_state_next = StVblank;
                            w_frame_end  = 1'b1;
                        end
                    end
                    StHblank: begin
                        if (w_sav_act) begin
                            w_state_next  = StLine;
                            w_cnt_restart = 1'b1;
                        end else if (w_eav_act) begin
                            w_code_err = 1'b1;
                        end else begin
                            w_state_next = StVblank;
                            w_frame_end  = 1'b1;
                        end
                    end
                    default: w_state_next = StIdle;
                endcase
            end
        end
    end

    assign w_pix_cnt_next  = (w_pix_out && (r_pix_cnt != '1)) ? r_pix_cnt + CNT_W'(1)
                                                               : r_pix_cnt;
    assign w_line_cnt_next = (w_line_done && (r_line_cnt != '1)) ? r_line_cnt + CNT_W'(1)
                                                                  : r_line_cnt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= StIdle;
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_tag         <= '0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_code_err    <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (I_data_valid) begin
                r_hist[0] <= I_data;
                r_hist[1] <= r_hist[0];
                r_hist[2] <= r_hist[1];
                r_hist[3] <= r_hist[2];
                // Preamble and code words are never pixels, so their tags are wiped.
                r_tag <= w_pre ? 4'b0000 : {r_tag[2:0], r_state == StLine};
            end
            r_data_valid <= w_pix_out;
            if (w_pix_out) r_data <= r_hist[3];
            r_pix_cnt <= w_cnt_restart ? '0 : w_pix_cnt_next;
            if (w_line_done) r_line_len <= w_pix_cnt_next;
            r_len_err <= w_line_done && (EXP_WIDTH != 0)
                         && (w_pix_cnt_next != CNT_W'(EXP_WIDTH));
            r_line_cnt <= w_frame_end ? '0 : w_line_cnt_next;
            if (w_frame_end) r_frame_lines <= w_line_cnt_next;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_code_err    <= w_code_err;
        end
    end

`ifdef SYNC_CODE_DECODER_LOCK_MON_EN
    localparam int unsigned LockW = $clog2(LOCK_TIMEOUT + 1);

    logic             r_bs_done_d1, r_lock_arm, r_bs_err;
    logic [LockW-1:0] r_lock_cnt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_bs_done_d1 <= 1'b0;
            r_lock_arm   <= 1'b0;
            r_bs_err     <= 1'b0;
            r_lock_cnt   <= '0;
        end else begin
            r_bs_done_d1 <= I_bitslip_done;
            if (I_bitslip_done && !r_bs_done_d1) begin
                r_lock_arm <= 1'b1;
                r_bs_err   <= 1'b0;
                r_lock_cnt <= '0;
            end else if (r_lock_arm && I_data_valid) begin
                if (w_pre && w_known) begin
                    r_lock_cnt <= '0;
                end else if (r_lock_cnt != LockW'(LOCK_TIMEOUT)) begin
                    r_lock_cnt <= r_lock_cnt + LockW'(1);
                    if (r_lock_cnt == LockW'(LOCK_TIMEOUT - 1)) r_bs_err <= 1'b1;
                end
            end
        end
    end

    assign O_bitslip_error = r_bs_err;
`endif

    assign O_frame_valid = (r_state == StLine) || (r_state == StHblank);
    assign O_line_valid  = (r_state == StLine);
    assign O_data_valid  = r_data_valid;
    assign O_data        = r_data;
    assign O_frame_start = r_frame_start;
    assign O_frame_end   = r_frame_end;
    assign O_line_len    = r_line_len;
    assign O_frame_lines = r_frame_lines;
    assign O_code_err    = r_code_err;
    assign O_len_err     = r_len_err;
endmodule
